uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving sample_en ticks per bit; legal values are even and >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sample_en, input, 1 bit: a one-clk pulse at OVERSAMPLE x baud rate, from the baud generator.
REQ-005 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-006 The block SHALL have port lcr, input, 3 bits, with this encoding:
- lcr[0]: parity enable.
- lcr[2:1] = 00: odd parity.
- lcr[2:1] = 01: even parity.
- lcr[2:1] = 10: parity bit forced 1.
- lcr[2:1] = 11: parity bit forced 0.
REQ-007 The block SHALL have port rx_ack, input, 1 bit: the consumer has taken rx_data.
REQ-008 The block SHALL have port rx_data, output, 8 bits: the received byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data and the error flags are valid; held until acked.
REQ-010 The block SHALL have port parity_err, output, 1 bit: the parity of the held byte mismatched.
REQ-011 The block SHALL have port frame_err, output, 1 bit: the stop bit of the held byte was sampled low.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky; a frame completed while rx_valid was still pending.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rxs.
REQ-015 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP, with a tick counter (0..OVERSAMPLE-1) and a 3-bit bit index.
REQ-016 IDLE -> START SHALL occur on a sample_en cycle with rxs = 0; the tick counter is cleared.
REQ-017 In START, at tick OVERSAMPLE/2-1 (mid-bit):
- rxs = 0: go to DATA with counter cleared.
- rxs = 1: false start; return to IDLE with no flags changed.
REQ-018 In DATA, PARITY and STOP, each bit SHALL be sampled when the counter reaches OVERSAMPLE-1; the counter then wraps to 0. Sampling therefore falls at bit centre.
REQ-019 DATA SHALL shift 8 bits in LSB first; after bit index 7 it goes to PARITY if lcr[0]=1, else to STOP.
REQ-020 The expected parity bit SHALL be computed as follows:
- odd: ~^data.
- even: ^data.
- forced: per lcr[2:1].
- The parity_err candidate = sampled bit != expected.
- The candidate is 0 when parity is disabled.
REQ-021 At the STOP sample the frame SHALL commit; the frame_err candidate = ~rxs; the state returns to IDLE in the same cycle, so back-to-back frames are supported.
REQ-022 On commit with rx_valid=0, or with rx_valid=1 and rx_ack=1 in the same cycle:
- rx_data, parity_err and frame_err load on the next edge.
- rx_valid = 1.
REQ-023 On commit with rx_valid=1 and rx_ack=0:
- The new byte is dropped.
- The held rx_data and flags are unchanged.
- overrun is set to 1.
REQ-024 rx_ack with rx_valid=1 and no commit SHALL clear rx_valid and overrun on the next edge; rx_data keeps its value. rx_ack with rx_valid=0 SHALL be ignored.
REQ-025 lcr SHALL be sampled when entering DATA and held for the frame; mid-frame lcr changes affect only the next frame.
REQ-026 Cycles without sample_en SHALL change no state, counter or shift register.
REQ-027 Latency SHALL be: rx_valid rises 1 clk after the stop-bit sample edge.

Reset
REQ-028 While rst=1 on a clk edge, the block SHALL reset as follows:
- state = IDLE.
- counter = 0, bit index = 0.
- rx_data = 0x00.
- rx_valid, parity_err, frame_err, overrun and busy = 0.
- synchronizer flops = 1.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no commit. After release, the block waits for a new falling edge; a still-low rx re-triggers START only through REQ-016.

Verification
REQ-030 OVERSAMPLE=16, lcr=011 (even parity), frame 0xA5 with parity 0 and stop 1 -> rx_valid=1, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-031 lcr=001 (odd parity), 0xA5 sent with parity bit 0 -> rx_data=0xA5, parity_err=1. lcr=101 (forced 1), same bit -> parity_err=1.
REQ-032 lcr=000, 0x3C sent with stop bit 0 -> rx_data=0x3C, frame_err=1. The next frame, 0x81 with rx_ack given between frames, -> rx_data=0x81, frame_err=0.
REQ-033 rx low pulse of 5 ticks in IDLE -> no rx_valid, busy returns to 0 within 8 ticks.
REQ-034 Two frames, 0x11 then 0x22, with no rx_ack -> rx_data=0x11, overrun=1. rx_ack -> rx_valid=0, overrun=0.
REQ-035 rst pulsed during DATA bit 4 -> all outputs 0 and busy=0. A subsequent full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_framer_if.sv
// Purpose : consumer-facing bundle of the UART receive framer (byte, status flags, ack).
// Latency : n/a (signal bundle only).
// Backpr. : rx_ack from the consumer releases the one-deep holding register.
//
// Signals:
//   rx_data    : received byte
//   rx_valid   : rx_data and flags valid, held until rx_ack
//   parity_err : parity mismatch on the held byte
//   frame_err  : stop bit of the held byte sampled low
//   overrun    : sticky, a frame was dropped while rx_valid was pending
//   rx_ack     : consumer has taken rx_data
interface uart_rx_framer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       rx_ack;

   // framer side
   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output overrun,
      input  rx_ack
   );

   // consumer side
   modport slave (
      input  rx_data,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  overrun,
      output rx_ack
   );
endinterface

// File: rtl/uart_rx_framer.sv
// Purpose : UART receive framer; oversampled start/data/parity/stop capture into a one-deep holding register.
// Latency : rx_valid rises one clk after the stop-bit centre sample.
// Backpr. : single holding register; a frame completing while it is un-acked is dropped and sets overrun.
//
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   sample_en : one-clk pulse at OVERSAMPLE x baud rate
//   rx        : asynchronous serial line, idle high
//   lcr       : [0] parity enable; [2:1] 00 odd, 01 even, 10 forced 1, 11 forced 0
//   busy      : framer is not idle
//   rx_if     : received byte, error flags, overrun and consumer ack
module uart_rx_framer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic             rx,
   input  logic [2:0]       lcr,
   output logic             busy,
   uart_rx_framer_if.master rx_if
);

   localparam int            CW       = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] TICK_MID = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] TICK_END = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer; both flops reset to the idle line level so a
   // reset never looks like a falling edge.
   // ------------------------------------------------------------------
   logic rx_meta_q;
   logic rxs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // ------------------------------------------------------------------
   // Framing state
   // ------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   tick_q,  tick_d;
   logic [2:0]      bit_q,   bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      lcr_q,   lcr_d;     // line control frozen for the current frame
   logic            pcand_q, pcand_d;   // parity error candidate of the current frame
   logic            exp_par;
   logic            commit;

   // Expected parity bit for the completed data byte.
   always_comb begin
      exp_par = 1'b0;
      case (lcr_q[2:1])
         2'b00:   exp_par = ~^shift_q;
         2'b01:   exp_par = ^shift_q;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         lcr_q   <= '0;
         pcand_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         lcr_q   <= lcr_d;
         pcand_q <= pcand_d;
      end
   end

   // Everything advances only on sample_en; other cycles hold all state.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      lcr_d   = lcr_q;
      pcand_d = pcand_q;
      commit  = 1'b0;

      if (sample_en) begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs_q) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end

            ST_START: begin
               // Mid-bit check rejects glitches shorter than half a bit.
               if (tick_q == TICK_MID) begin
                  tick_d = '0;
                  if (!rxs_q) begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                     lcr_d   = lcr;
                     pcand_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end

            ST_DATA: begin
               if (tick_q == TICK_END) begin
                  tick_d  = '0;
                  shift_d = {rxs_q, shift_q[7:1]};   // LSB arrives first
                  if (bit_q == 3'd7) begin
                     bit_d   = '0;
                     state_d = lcr_q[0] ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end

            ST_PARITY: begin
               if (tick_q == TICK_END) begin
                  tick_d  = '0;
                  pcand_d = (rxs_q != exp_par);
                  state_d = ST_STOP;
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end

            ST_STOP: begin
               // Return to IDLE at the stop centre so the next start edge
               // can be caught during the second half of the stop bit.
               if (tick_q == TICK_END) begin
                  tick_d  = '0;
                  commit  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end

            default: begin
               state_d = ST_IDLE;
               tick_d  = '0;
            end
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);

   // ------------------------------------------------------------------
   // Holding register towards the consumer
   // ------------------------------------------------------------------
   logic [7:0] data_q,  data_d;
   logic       valid_q, valid_d;
   logic       perr_q,  perr_d;
   logic       ferr_q,  ferr_d;
   logic       ovr_q,   ovr_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (commit) begin
         // An ack in the commit cycle frees the register for the new byte.
         if (!valid_q || rx_if.rx_ack) begin
            data_d  = shift_q;
            perr_d  = pcand_q;
            ferr_d  = ~rxs_q;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_if.rx_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_if.rx_data    = data_q;
   assign rx_if.rx_valid   = valid_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.frame_err  = ferr_q;
   assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Purpose : self-checking bench for uart_rx_framer with a frame-level reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_uart_rx_framer;
   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_en;
   logic       rx;
   logic [2:0] lcr;
   logic       busy;
   int         se_gap;
   int         checks;
   int         errors;

   // reference model of the consumer-visible state
   logic       exp_valid;
   logic [7:0] exp_data;
   logic       exp_perr;
   logic       exp_ferr;
   logic       exp_ovr;

   uart_rx_framer_if bus ();

   uart_rx_framer #(.OVERSAMPLE(OS)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .rx        (rx),
      .lcr       (lcr),
      .busy      (busy),
      .rx_if     (bus)
   );

   always #5 clk = ~clk;

   // sample_en with irregular spacing of 3..4 clocks
   initial begin
      sample_en = 1'b0;
      se_gap    = 0;
      forever begin
         @(negedge clk);
         if (se_gap == 0) begin
            sample_en = 1'b1;
            se_gap    = $urandom_range(2, 3);
         end else begin
            sample_en = 1'b0;
            se_gap--;
         end
      end
   end

   wire [12:0] obs = {bus.rx_valid, bus.rx_data, bus.parity_err, bus.frame_err, bus.overrun, busy};

   // ---------------- reference model ----------------
   function automatic logic par_expected(input logic [7:0] d, input logic [2:0] l);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      case (l[2:1])
         2'b00:   return (ones % 2) == 0;   // odd: total count of ones odd
         2'b01:   return (ones % 2) == 1;   // even
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_commit(input logic [7:0] d, input logic perr, input logic ferr);
      if (!exp_valid) begin
         exp_valid = 1'b1;
         exp_data  = d;
         exp_perr  = perr;
         exp_ferr  = ferr;
      end else begin
         exp_ovr = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_perr  = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (sample_en !== 1'b1);
      end
      @(negedge clk);
   endtask

   // lcr in force at the start bit governs the frame; lcr_mid is applied
   // during data bit 2 and only governs later frames.
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop_bit,
                             input logic [2:0] lcr_mid);
      logic [2:0] l;
      logic       perr;
      l  = lcr;
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_ticks(OS);
         if (i == 2) lcr = lcr_mid;
      end
      if (l[0]) begin
         rx = pb;
         wait_ticks(OS);
      end
      if (stop_bit) begin
         rx = 1'b1;
         wait_ticks(OS);
      end else begin
         // short low stop, then idle long enough to resolve a false start
         rx = 1'b0;
         wait_ticks(12);
         rx = 1'b1;
         wait_ticks(OS);
      end
      perr = l[0] ? (pb != par_expected(d, l)) : 1'b0;
      model_commit(d, perr, !stop_bit);
   endtask

   task automatic do_ack();
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
      @(negedge clk);
      if (exp_valid) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL reset_state got %h want %h", obs, 13'h0);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL reset_idle got %h want %h", obs, 13'h0);
      end
   endtask

   task automatic test_even_parity();
      lcr = 3'b011;
      send_frame(8'hA5, 1'b0, 1'b1, 3'b011);
      checks++;
      if (obs !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL even_a5 got %h want %h", obs, {1'b1, 8'hA5, 4'b0000});
      end
      do_ack();
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'hA5) begin
         errors++;
         $display("FAIL ack_clear got valid=%b data=%h want valid=0 data=a5", bus.rx_valid, bus.rx_data);
      end
   endtask

   task automatic test_parity_err();
      lcr = 3'b001;
      send_frame(8'hA5, 1'b0, 1'b1, 3'b101);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5 || bus.parity_err !== 1'b1) begin
         errors++;
         $display("FAIL odd_perr got %h want valid=1 data=a5 perr=1", obs);
      end
      do_ack();
      send_frame(8'hA5, 1'b0, 1'b1, 3'b111);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.parity_err !== 1'b1) begin
         errors++;
         $display("FAIL force1_perr got %h want valid=1 perr=1", obs);
      end
      do_ack();
      send_frame(8'hA5, 1'b0, 1'b1, 3'b000);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
         errors++;
         $display("FAIL force0_ok got %h want valid=1 perr=0", obs);
      end
      do_ack();
   endtask

   task automatic test_frame_err();
      lcr = 3'b000;
      send_frame(8'h3C, 1'b0, 1'b0, 3'b000);
      checks++;
      if (obs !== {1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ferr_3c got %h want %h", obs, {1'b1, 8'h3C, 4'b0100});
      end
      do_ack();
      send_frame(8'h81, 1'b0, 1'b1, 3'b000);
      checks++;
      if (obs !== {1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL after_ferr_81 got %h want %h", obs, {1'b1, 8'h81, 4'b0000});
      end
      do_ack();
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      wait_ticks(5);
      rx = 1'b1;
      wait_ticks(8);
      checks++;
      if (busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL glitch got busy=%b valid=%b want busy=0 valid=0", busy, bus.rx_valid);
      end
   endtask

   task automatic test_overrun();
      lcr = 3'b000;
      send_frame(8'h11, 1'b0, 1'b1, 3'b000);
      send_frame(8'h22, 1'b0, 1'b1, 3'b000);
      checks++;
      if (obs !== {1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL overrun got %h want %h", obs, {1'b1, 8'h11, 4'b0010});
      end
      do_ack();
      checks++;
      if (obs !== {1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL overrun_ack got %h want %h", obs, {1'b0, 8'h11, 4'b0000});
      end
      do_ack();   // ack with nothing pending is ignored
      checks++;
      if (obs !== {1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL idle_ack got %h want %h", obs, {1'b0, 8'h11, 4'b0000});
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      // leave a byte with both error flags pending
      lcr = 3'b001;
      send_frame(8'hFF, 1'b0, 1'b0, 3'b000);
      d  = 8'h5A;
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         wait_ticks(OS);
      end
      rx = d[4];
      wait_ticks(6);
      checks++;
      if (busy !== 1'b1 || bus.rx_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst got busy=%b valid=%b want busy=1 valid=1", busy, bus.rx_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL midframe_rst got %h want %h", obs, 13'h0);
      end
      rx  = 1'b1;
      rst = 1'b0;
      model_reset();
      wait_ticks(OS + 4);
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL post_rst_idle got %h want %h", obs, 13'h0);
      end
      send_frame(8'h5A, 1'b0, 1'b1, 3'b000);
      checks++;
      if (obs !== {1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_rst_5a got %h want %h", obs, {1'b1, 8'h5A, 4'b0000});
      end
      do_ack();
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       pb;
      logic       sb;
      logic [2:0] lm;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) do_ack();
         d  = 8'($urandom);
         pb = 1'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         lm = 3'($urandom);
         send_frame(d, pb, sb, lm);
         checks++;
         if (obs !== {exp_valid, exp_data, exp_perr, exp_ferr, exp_ovr, 1'b0}) begin
            errors++;
            $display("FAIL random_%0d got %h want %h", n, obs,
                     {exp_valid, exp_data, exp_perr, exp_ferr, exp_ovr, 1'b0});
         end
      end
      do_ack();
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.rx_data !== exp_data) begin
         errors++;
         $display("FAIL random_final_ack got %h want valid=0 ovr=0 data=%h", obs, exp_data);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      rx         = 1'b1;
      lcr        = 3'b000;
      bus.rx_ack = 1'b0;
      model_reset();

      test_reset();
      test_even_parity();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_overrun();
      test_reset_midframe();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
